// File: rtl/fp_add_arbiter_if.sv
// Request/adder/response bundle for fp_add_arbiter; slave = arbiter side, master = environment side.
// Carries doRspFlags only when FP_ADD_ARBITER_FLAGS_EN is defined.
interface fp_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   ciReqValid;
  logic [NREQ-1:0]   coReqReady;
  logic [NREQ*W-1:0] diReqA;
  logic [NREQ*W-1:0] diReqB;
  logic [NREQ-1:0]   ciReqADD_n;
  logic [W-1:0]      doAdA;
  logic [W-1:0]      doAdB;
  logic              coAdADD_n;
  logic [W-1:0]      diAdY;
  logic              coRspValid;
  logic              ciRspReady;
  logic [W-1:0]      doRspY;
  logic [IDW-1:0]    doRspId;
  logic              coBusy;
`ifdef FP_ADD_ARBITER_FLAGS_EN
  logic [3:0]        doRspFlags;
`endif

  modport slave (
    input  ciReqValid, diReqA, diReqB, ciReqADD_n, diAdY, ciRspReady,
    output coReqReady, doAdA, doAdB, coAdADD_n, coRspValid, doRspY, doRspId, coBusy
`ifdef FP_ADD_ARBITER_FLAGS_EN
    , output doRspFlags
`endif
  );

  modport master (
    output ciReqValid, diReqA, diReqB, ciReqADD_n, diAdY, ciRspReady,
    input  coReqReady, doAdA, doAdB, coAdADD_n, coRspValid, doRspY, doRspId, coBusy
`ifdef FP_ADD_ARBITER_FLAGS_EN
    , input doRspFlags
`endif
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one combinational FP adder among NREQ requesters (multicycle adder path).
// Define FP_ADD_ARBITER_FLAGS_EN to add zero/inf/NaN/sign flags registered alongside the result.
module fp_add_arbiter #(
  parameter int LOGWIDTH  = 5,
  parameter int EXPWIDTH  = 8,
  parameter int MANTWIDTH = 23,
  parameter int NREQ      = 4,
  parameter int ADD_LAT   = 2
) (
  input logic             ciClk,
  input logic             ciRst_n,
  fp_add_arbiter_if.slave bus
);
  localparam int W    = 2 ** LOGWIDTH;
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = 4;

  if (W != EXPWIDTH + MANTWIDTH + 1) begin : g_bad_format
    $error("fp_add_arbiter: 2**LOGWIDTH must equal EXPWIDTH+MANTWIDTH+1");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("fp_add_arbiter: NREQ must be in 2..16");
  end
  if (ADD_LAT < 1 || ADD_LAT > 15) begin : g_bad_lat
    $error("fp_add_arbiter: ADD_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic [W-1:0]    ad_a_q;
  logic [W-1:0]    ad_b_q;
  logic            ad_sub_q;
  logic [W-1:0]    rsp_y_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_vld_q;

  logic            gnt_vld;
  logic [IDW-1:0]  ptr_d;
  logic [IDW-1:0]  probe;
  logic            take_d;

`ifdef FP_ADD_ARBITER_FLAGS_EN
  logic [3:0]      rsp_fl_q;

  function automatic logic [3:0] fp_flags(input logic [W-1:0] y);
    logic exp_ones, exp_zero, frac_zero;
    exp_ones  = &y[W-2 -: EXPWIDTH];
    exp_zero  = ~|y[W-2 -: EXPWIDTH];
    frac_zero = ~|y[MANTWIDTH-1:0];
    return {y[W-1], exp_ones & ~frac_zero, exp_ones & frac_zero, exp_zero & frac_zero};
  endfunction

  assign bus.doRspFlags = rsp_fl_q;
`endif

  // Search ptr+1, ptr+2, ... modulo NREQ; the nearest set index is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    ptr_d   = ptr_q;
    probe   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      probe = IDW'((int'(ptr_q) + k) % NREQ);
      if (bus.ciReqValid[probe]) begin
        gnt_vld = 1'b1;
        ptr_d   = probe;
      end
    end
  end

  // A grant is taken from IDLE, or from RESP on the same edge as the response handshake.
  assign take_d = ciRst_n && gnt_vld &&
                  ((state_q == IDLE) || (state_q == RESP && bus.ciRspReady));

  assign bus.coReqReady = take_d ? (NREQ'(1) << ptr_d) : '0;
  assign bus.doAdA      = ad_a_q;
  assign bus.doAdB      = ad_b_q;
  assign bus.coAdADD_n  = ad_sub_q;
  assign bus.coRspValid = rsp_vld_q;
  assign bus.doRspY     = rsp_y_q;
  assign bus.doRspId    = rsp_id_q;
  assign bus.coBusy     = (state_q != IDLE);

  always_ff @(posedge ciClk or negedge ciRst_n) begin
    if (!ciRst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      cnt_q     <= '0;
      ad_a_q    <= '0;
      ad_b_q    <= '0;
      ad_sub_q  <= 1'b0;
      rsp_y_q   <= '0;
      rsp_id_q  <= '0;
      rsp_vld_q <= 1'b0;
`ifdef FP_ADD_ARBITER_FLAGS_EN
      rsp_fl_q  <= '0;
`endif
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_y_q   <= bus.diAdY;
`ifdef FP_ADD_ARBITER_FLAGS_EN
            rsp_fl_q  <= fp_flags(bus.diAdY);
`endif
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        RESP: begin
          if (bus.ciRspReady) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: ;
      endcase
      // Overrides the RESP->IDLE move above for back-to-back operation.
      if (take_d) begin
        ad_a_q   <= bus.diReqA[ptr_d*W +: W];
        ad_b_q   <= bus.diReqB[ptr_d*W +: W];
        ad_sub_q <= bus.ciReqADD_n[ptr_d];
        rsp_id_q <= ptr_d;
        ptr_q    <= ptr_d;
        cnt_q    <= CNTW'(ADD_LAT - 1);
        state_q  <= WAIT;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [W-1:0]   y;
    logic [IDW-1:0] id;
    logic [3:0]     fl;
  } rsp_t;

  logic ciClk   = 1'b0;
  logic ciRst_n = 1'b0;
  always #5 ciClk = ~ciClk;

  fp_add_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  fp_add_arbiter #(
    .LOGWIDTH(5), .EXPWIDTH(8), .MANTWIDTH(23), .NREQ(NREQ), .ADD_LAT(2)
  ) dut (
    .ciClk   (ciClk),
    .ciRst_n (ciRst_n),
    .bus     (bus)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  rsp_t sb_q[$];
  int   hs_cyc[$];
  rsp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Stand-in adder: two real IEEE cases, otherwise a bench-known XOR pattern.
  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return a ^ b;
  endfunction

  always_comb bus.diAdY = fadd(bus.doAdA, bus.doAdB, bus.coAdADD_n);

  always @(posedge ciClk) cyc <= cyc + 1;

  always @(negedge ciClk) begin
    if (ciRst_n && bus.coRspValid && bus.ciRspReady) begin
      hs_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_y", bus.doRspY, mon_e.y);
        chk("rsp_id", bus.doRspId, mon_e.id);
`ifdef FP_ADD_ARBITER_FLAGS_EN
        chk("rsp_flags", bus.doRspFlags, mon_e.fl);
`endif
      end
    end
  end

  task automatic tick;
    @(posedge ciClk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.diReqA[i*W +: W] = a;
    bus.diReqB[i*W +: W] = b;
    bus.ciReqADD_n[i]    = sub;
  endtask

  task automatic push(input logic [W-1:0] y, input int id, input logic [3:0] fl);
    sb_q.push_back('{y: y, id: IDW'(id), fl: fl});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.coBusy || bus.coRspValid) && n < 20) begin
      tick;
      n++;
    end
    chk(name, {62'd0, bus.coBusy, bus.coRspValid}, 64'd0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.coRspValid && n < 12) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n;
    bus.ciReqValid = '1;
    bus.diReqA     = '0;
    bus.diReqB     = '0;
    bus.ciReqADD_n = '0;
    bus.ciRspReady = 1'b1;

    // Reset state, with every request valid held high.
    repeat (2) tick;
    chk("rst_ready", bus.coReqReady, 4'b0000);
    chk("rst_busy", bus.coBusy, 0);
    chk("rst_valid", bus.coRspValid, 0);
    chk("rst_rspy", bus.doRspY, 0);
    chk("rst_ada", bus.doAdA, 0);

    // Round robin from reset: 0,1,2,3,0 with handshakes 3 cycles apart.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h10 + i, 32'h100, 1'b0);
    for (int i = 0; i < 5; i++) push(32'h110 + (i % 4), i % 4, 4'b0000);
    ciRst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge ciClk);
        n++;
      end while (bus.coReqReady == '0 && n < 20);
      chk("rr_grant", bus.coReqReady, 4'b0001 << (g % 4));
      tick;
      if (g == 4) bus.ciReqValid = '0;
    end
    wait_idle("rr_idle");
    chk("rr_count", hs_cyc.size(), 5);
    if (hs_cyc.size() >= 5)
      for (int i = 1; i < 5; i++) chk("rr_spacing", hs_cyc[i] - hs_cyc[i-1], 3);

    // Single request from requester 2.
    set_req(2, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    bus.ciReqValid = 4'b0100;
    #1;
    chk("single_ready", bus.coReqReady, 4'b0100);
    push(32'h4040_0000, 2, 4'b0000);
    tick;
    bus.ciReqValid = '0;
    #1;
    chk("single_ready_drop", bus.coReqReady, 4'b0000);
    chk("single_busy", bus.coBusy, 1);
    n = 1;
    while (!bus.coRspValid && n < 12) begin
      tick;
      n++;
    end
    chk("single_latency", n, 3);
    wait_idle("single_idle");

    // Subtract path from requester 1.
    set_req(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    bus.ciReqValid = 4'b0010;
    #1;
    chk("sub_ready", bus.coReqReady, 4'b0010);
    push(32'h4000_0000, 1, 4'b0000);
    tick;
    bus.ciReqValid = '0;
    #1;
    chk("sub_addn", bus.coAdADD_n, 1);
    chk("sub_adb", bus.doAdB, 32'h3F80_0000);
    chk("sub_ada", bus.doAdA, 32'h4040_0000);
    tick;
    chk("sub_adb_hold", bus.doAdB, 32'h3F80_0000);
    wait_idle("sub_idle");

    // Backpressure in RESP with requester 0 pending.
    bus.ciRspReady = 1'b0;
    set_req(3, 32'h13, 32'h100, 1'b0);
    bus.ciReqValid = 4'b1000;
    push(32'h113, 3, 4'b0000);
    tick;
    set_req(0, 32'h10, 32'h100, 1'b0);
    bus.ciReqValid = 4'b0001;
    push(32'h110, 0, 4'b0000);
    wait_valid(n);
    chk("bp_valid", bus.coRspValid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_ready", bus.coReqReady, 4'b0000);
      chk("bp_rspy_stable", bus.doRspY, 32'h113);
      chk("bp_id_stable", bus.doRspId, 3);
      tick;
    end
    bus.ciRspReady = 1'b1;
    #1;
    chk("bp_grant_ready", bus.coReqReady, 4'b0001);
    tick;
    bus.ciReqValid = '0;
    #1;
    chk("bp_regrant_id", bus.doRspId, 0);
    chk("bp_regrant_ada", bus.doAdA, 32'h10);
    chk("bp_valid_drop", bus.coRspValid, 0);
    wait_idle("bp_idle");

    // Reset during WAIT; a requester-1 grant left ptr at 1.
    set_req(1, 32'h11, 32'h100, 1'b1);
    bus.ciReqValid = 4'b0010;
    tick;
    bus.ciReqValid = '0;
    tick;
    #2;
    ciRst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.coBusy, 0);
    chk("mid_rst_valid", bus.coRspValid, 0);
    chk("mid_rst_ada", bus.doAdA, 0);
    chk("mid_rst_adb", bus.doAdB, 0);
    chk("mid_rst_addn", bus.coAdADD_n, 0);
    chk("mid_rst_id", bus.doRspId, 0);
    chk("mid_rst_rspy", bus.doRspY, 0);
    #3;
    ciRst_n = 1'b1;
    set_req(0, 32'h10, 32'h100, 1'b0);
    set_req(3, 32'h13, 32'h100, 1'b0);
    bus.ciReqValid = 4'b1001;
    #1;
    chk("post_rst_grant", bus.coReqReady, 4'b0001);
    push(32'h110, 0, 4'b0000);
    tick;
    bus.ciReqValid = '0;
    wait_idle("post_rst_idle");

`ifdef FP_ADD_ARBITER_FLAGS_EN
    // Flag decode on NaN, -inf and zero results.
    set_req(2, 32'h7FC0_0000, 32'h0, 1'b0);
    bus.ciReqValid = 4'b0100;
    push(32'h7FC0_0000, 2, 4'b0100);
    tick;
    bus.ciReqValid = '0;
    wait_idle("flag_nan_idle");
    set_req(2, 32'hFF80_0000, 32'h0, 1'b0);
    bus.ciReqValid = 4'b0100;
    push(32'hFF80_0000, 2, 4'b1010);
    tick;
    bus.ciReqValid = '0;
    wait_idle("flag_inf_idle");
    set_req(2, 32'h1234_5678, 32'h1234_5678, 1'b0);
    bus.ciReqValid = 4'b0100;
    push(32'h0, 2, 4'b0001);
    tick;
    bus.ciReqValid = '0;
    wait_idle("flag_zero_idle");
`endif

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick;
      n++;
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
